data_cache: RTL
===============

// Module: data_cache
// PURPOSE
//  Responder for the pipeline's data-memory port: direct-mapped, write-back, write-allocate cache.
//  Accepts word loads/stores from MEM stage via valid/ready; a miss holds ready low so the CPU stalls.
//  Refills and evicts whole lines over a valid/ready line interface to a multi-cycle backing memory.
// PARAMETERS
//  LINE_WORDS  4   32-bit words per line (power of 2, >=2)
//  NUM_SETS    16  number of lines/sets (power of 2)
//  ADDR_W      32  byte-address width
// PORTS
//  clk             in   1                clock
//  reset           in   1                synchronous, active-high
//  req_valid       in   1                CPU request present (MEM-stage mem_read|mem_write)
//  req_write       in   1                1=store, 0=load
//  req_addr        in   ADDR_W           byte address; [1:0] ignored (word access only)
//  req_wdata       in   32               store data
//  req_ready       out  1                cache can accept a request this cycle
//  resp_valid      out  1                one-cycle pulse: request done (load data valid)
//  resp_rdata      out  32               load data (0 for stores)
//  resp_hit        out  1                request hit without refill (qualified by resp_valid)
//  mem_req_valid   out  1                line request to backing memory
//  mem_req_ready   in   1                backing memory accepts request
//  mem_req_write   out  1                1=writeback, 0=refill read
//  mem_req_addr    out  ADDR_W           line-aligned address
//  mem_req_wdata   out  32*LINE_WORDS    evicted line, word 0 in LSBs
//  mem_resp_valid  in   1                refill data returned (one cycle)
//  mem_resp_rdata  in   32*LINE_WORDS    refill line
//  hit_count       out  32               see CONFIGURATION
//  miss_count      out  32               see CONFIGURATION
// BEHAVIOUR
//  Address split: offset=[OFF_W+1:2], index=[IDX_W+OFF_W+1:OFF_W+2], tag=remaining MSBs.
//  FSM: IDLE -> TAG_CHECK -> {IDLE | WRITE_BACK | ALLOCATE}; WRITE_BACK -> ALLOCATE -> TAG_CHECK.
//  IDLE: req_ready=1 (only state where it is 1); req_valid&&req_ready latches the request -> TAG_CHECK.
//  TAG_CHECK hit (valid && tag match): resp_valid=1 this cycle, resp_rdata=word; store writes word, sets dirty; -> IDLE.
//   Hit latency: accepted at edge N -> resp_valid high in cycle N+1; next accept possible at edge N+2.
//  TAG_CHECK miss: victim dirty -> WRITE_BACK, else -> ALLOCATE. resp_hit=0 on the eventual response.
//  WRITE_BACK: mem_req_valid=1, write=1, addr={victim tag,index,0}, wdata=victim line; on handshake -> ALLOCATE, clear dirty.
//  ALLOCATE: mem_req_valid=1, write=0 until handshake; then wait mem_resp_valid; fill line, valid=1, dirty=0, tag=req tag -> TAG_CHECK (now hits; store merges then).
//  mem_req_valid/write/addr/wdata held stable until mem_req_ready; mem_resp_valid outside ALLOCATE-wait ignored.
//  req_* inputs ignored unless IDLE; latched request is not affected by input changes during a miss.
//  Reset (any state, including mid-miss): state=IDLE, all valid/dirty=0, req_ready=1 on next cycle, resp_valid=0,
//   resp_rdata=0, resp_hit=0, mem_req_valid=0, counters=0; an in-flight memory transaction is abandoned.
//  Data array contents need no reset. Counters wrap at 2^32.
// CONFIGURATION
//  DCACHE_STATS_EN defined: hit_count/miss_count incremented once per completed request (by resp_hit).
//  Not defined: counter logic absent, hit_count=miss_count=0 constant.
// STRUCTURE
//  dcache_pkg: state enum, OFF_W/IDX_W/TAG_W localparams derived from parameters, line_t typedef.
//  Sub-module dcache_mem_array: tag/valid/dirty/data storage with per-word write enable and full-line fill port.
// TESTING (memory model: mem_req_ready=1, refill latency 3 cycles unless stated; line 0x100 = {0x44,0x33,0x22,0x11})
//  1 Cold load 0x104 -> one refill read addr 0x100, resp_rdata=0x22, resp_hit=0, miss_count=1.
//  2 Then load 0x108 -> resp_valid in cycle after accept, rdata=0x33, resp_hit=1, no mem_req_valid.
//  3 Store 0xDEADBEEF @0x10C (hit), then load 0x200 -> writeback addr 0x100 word3=0xDEADBEEF, then refill 0x200.
//  4 Hold mem_req_ready=0 for 5 cycles on a miss -> mem_req_* stable, req_ready=0 throughout, completes after.
//  5 Reset asserted during ALLOCATE wait -> next cycle req_ready=1, mem_req_valid=0; load 0x104 misses again.
//  6 Store 0x55 @0x304 to clean set 0 -> refill 0x300, no writeback; load 0x304 -> hit, rdata=0x55.

Source files
------------

// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
//   Shared types and default geometry for the data cache.
//   - DEF_LINE_WORDS / DEF_NUM_SETS / DEF_ADDR_W : default cache geometry
//   - OFF_W / IDX_W / TAG_W : word-offset, set-index and tag widths derived
//     from the default geometry (byte offset [1:0] is never part of these)
//   - line_t  : one cache line, word 0 in the LSBs
//   - state_e : controller states
// ----------------------------------------------------------------------------
package dcache_pkg;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_SETS   = 16;
  localparam int DEF_ADDR_W     = 32;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_NUM_SETS);
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 2;

  typedef logic [32*DEF_LINE_WORDS-1:0] line_t;

  // ST_ALLOC_WAIT is the second half of allocation: the refill read has been
  // accepted and the line is awaited from backing memory.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG_CHECK,
    ST_WRITE_BACK,
    ST_ALLOCATE,
    ST_ALLOC_WAIT
  } state_e;

endpackage

// File: rtl/dcache_mem_array.sv
// ----------------------------------------------------------------------------
// dcache_mem_array
//   Tag / valid / dirty / data storage for a direct-mapped cache.
//   All operations address the single set selected by 'index'.
//   Ports:
//     clk, reset        clock, synchronous active-high reset (valid/dirty only)
//     index             set being read / written
//     rd_valid/rd_dirty/rd_tag/rd_line   combinational read of that set
//     wr_en, wr_off, wr_data             single-word store, marks line dirty
//     fill_en, fill_tag, fill_line       whole-line refill, valid=1 dirty=0
//     clean_en                           clear dirty after a writeback
// ----------------------------------------------------------------------------
module dcache_mem_array
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(NUM_SETS)-1:0]   index,
  output logic                          rd_valid,
  output logic                          rd_dirty,
  output logic [ADDR_W-$clog2(NUM_SETS)-$clog2(LINE_WORDS)-3:0] rd_tag,
  output logic [32*LINE_WORDS-1:0]      rd_line,
  input  logic                          wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
  input  logic [31:0]                   wr_data,
  input  logic                          fill_en,
  input  logic [ADDR_W-$clog2(NUM_SETS)-$clog2(LINE_WORDS)-3:0] fill_tag,
  input  logic [32*LINE_WORDS-1:0]      fill_line,
  input  logic                          clean_en
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS - 2;
  localparam int LINE_W   = 32 * LINE_WORDS;

  logic [TAG_BITS-1:0] tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (wr_en) begin
        dirty_q[index] <= 1'b1;
      end else if (clean_en) begin
        dirty_q[index] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; a line is only ever read
  // through its valid bit, so clearing valid is enough and keeps the
  // arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_line;
    end else if (wr_en) begin
      data_mem[index][wr_off*32 +: 32] <= wr_data;
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_line  = data_mem[index];

endmodule

// File: rtl/data_cache.sv
// ----------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-back, write-allocate data cache sitting on the
//   pipeline's MEM-stage port. A miss holds req_ready low until the line has
//   been (written back and) refilled from a multi-cycle backing memory.
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     req_valid/req_write/req_addr/req_wdata/req_ready   CPU word request
//     resp_valid/resp_rdata/resp_hit one-cycle completion pulse
//     mem_req_valid/ready/write/addr/wdata   line request to backing memory
//     mem_resp_valid/mem_resp_rdata          refill line return
//     hit_count/miss_count           completed-request statistics
//   Build option: define DCACHE_STATS_EN to implement the hit/miss counters;
//   otherwise both outputs are constant zero.
// ----------------------------------------------------------------------------
module data_cache
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_hit,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_write,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_rdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS - 2;

  state_e state_q, state_d;

  // Latched request; the byte offset is dropped since only words are accessed.
  logic                req_write_q;
  logic [ADDR_W-3:0]   req_word_q;
  logic [31:0]         req_wdata_q;
  logic                missed_q;   // this request has already missed once

  logic unused_byte_offset;
  assign unused_byte_offset = ^req_addr[1:0];

  logic [OFF_BITS-1:0] req_off;
  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] req_tag;
  assign req_off = req_word_q[OFF_BITS-1:0];
  assign req_idx = req_word_q[OFF_BITS +: IDX_BITS];
  assign req_tag = req_word_q[OFF_BITS+IDX_BITS +: TAG_BITS];

  logic                     rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]      rd_tag;
  logic [32*LINE_WORDS-1:0] rd_line;
  logic                     wr_en, fill_en, clean_en;
  logic                     hit;

  dcache_mem_array #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_SETS   (NUM_SETS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (req_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_off    (req_off),
    .wr_data   (req_wdata_q),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_line (mem_resp_rdata),
    .clean_en  (clean_en)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      missed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        req_write_q <= req_write;
        req_word_q  <= req_addr[ADDR_W-1:2];
        req_wdata_q <= req_wdata;
        missed_q    <= 1'b0;
      end else if (state_q == ST_TAG_CHECK && !hit) begin
        missed_q <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    clean_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_TAG_CHECK;
      end
      ST_TAG_CHECK: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = !missed_q;
          resp_rdata = req_write_q ? 32'd0 : rd_line[req_off*32 +: 32];
          wr_en      = req_write_q;
          state_d    = ST_IDLE;
        end else if (rd_valid && rd_dirty) begin
          state_d = ST_WRITE_BACK;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end
      ST_WRITE_BACK: begin
        // Victim tag/line come straight from the array, which cannot change
        // until the handshake, so the request stays stable while stalled.
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {rd_tag, req_idx, {(OFF_BITS+2){1'b0}}};
        mem_req_wdata = rd_line;
        if (mem_req_ready) begin
          clean_en = 1'b1;
          state_d  = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, {(OFF_BITS+2){1'b0}}};
        if (mem_req_ready) state_d = ST_ALLOC_WAIT;
      end
      ST_ALLOC_WAIT: begin
        if (mem_resp_valid) begin
          fill_en = 1'b1;
          state_d = ST_TAG_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (resp_valid) begin
      if (resp_hit) hit_q  <= hit_q + 32'd1;
      else          miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
